// File: rtl/ram_scan_display_if.sv
// ram_scan_display_if: port-side bus of the scanned RAM (access, clear control, status).
// The master drives chip select, write enable, address, write data and the clear pulse;
// the slave (the RAM) returns registered read data, its valid flag and the busy flag.
interface ram_scan_display_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
);
    logic              cs_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              clear_req;
    logic              busy;

    modport master (
        output cs_n,
        output we_n,
        output addr,
        output data_in,
        output clear_req,
        input  data_out,
        input  data_oe,
        input  busy
    );

    modport slave (
        input  cs_n,
        input  we_n,
        input  addr,
        input  data_in,
        input  clear_req,
        output data_out,
        output data_oe,
        output busy
    );
endinterface

// File: rtl/ram_scan_display.sv
// ram_scan_display: single-port RAM with optional inverted read, a bulk-clear sequencer
// and a free-running scan engine that shows every word on an active-low 7-segment digit.
// Optional feature: define RAM_CLEAR_ON_RESET_EN to start a bulk clear automatically on
// the first cycle after reset is released (memory powers up all-zero).
module ram_scan_display #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned INVERT_OUT = 1
) (
    input  logic              clk,
    input  logic              reset,
    ram_scan_display_if.slave bus,
    output logic [6:0]        seg,
    output logic [ADDR_W-1:0] digit_sel
);

    localparam int unsigned       DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {StIdle, StClear} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              clear_start;
    logic              port_in_range;
    logic              port_access;
    logic              port_write;
    logic              port_read;
    logic [DATA_W-1:0] rd_word;

    logic [DIV_W-1:0]  div_cnt;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_word;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef RAM_CLEAR_ON_RESET_EN
    logic auto_clr;

    // One-shot flag: set by reset, consumed on the first running cycle to launch a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_clr <= 1'b1;
        end else begin
            auto_clr <= 1'b0;
        end
    end
`endif

    // Next-state decode and port access qualification; a clear request wins over the port.
    always_comb begin
`ifdef RAM_CLEAR_ON_RESET_EN
        clear_start = bus.clear_req | auto_clr;
`else
        clear_start = bus.clear_req;
`endif
        state_next = state;
        if (state == StIdle) begin
            if (clear_start) begin
                state_next = StClear;
            end
        end else begin
            if (clr_addr == LAST_ADDR) begin
                state_next = StIdle;
            end
        end
        port_in_range = ({1'b0, bus.addr} < DEPTH_EXT);
        port_access   = (state == StIdle) && !clear_start && !bus.cs_n;
        port_write    = port_access && !bus.we_n && port_in_range;
        port_read     = port_access && bus.we_n;
        // Out-of-range words read as zero.
        rd_word       = port_in_range ? mem[bus.addr] : '0;
        scan_word     = mem[scan_addr];
    end

    // Memory array: never reset, but a reset edge blocks any write (aborts a clear in place).
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == StClear) begin
                mem[clr_addr] <= '0;
            end else if (port_write) begin
                mem[bus.addr] <= bus.data_in;
            end
        end
    end

    // Clear FSM with registered busy and registered read port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            clr_addr     <= '0;
            bus.busy     <= 1'b0;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
        end else begin
            state    <= state_next;
            bus.busy <= (state_next == StClear);
            if ((state == StClear) && (state_next == StClear)) begin
                clr_addr <= clr_addr + ADDR_ONE;
            end else begin
                clr_addr <= '0;
            end
            if (port_read) begin
                bus.data_out <= (INVERT_OUT != 0) ? ~rd_word : rd_word;
                bus.data_oe  <= 1'b1;
            end else begin
                bus.data_out <= '0;
                bus.data_oe  <= 1'b0;
            end
        end
    end

    // Scan engine: divider steps the scan address; display registers lag it by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            scan_addr <= '0;
            seg       <= SEG_BLANK;
            digit_sel <= '0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + ADDR_ONE;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end
            digit_sel <= scan_addr;
            // Blank exactly while busy is high; true data otherwise.
            seg <= (state_next == StClear) ? SEG_BLANK : hex7(scan_word[3:0]);
        end
    end

endmodule

// File: tb/tb_ram_scan_display.sv
// tb_ram_scan_display: directed self-checking bench for ram_scan_display.
// dut_a: DEPTH=16, SCAN_DIV=4, inverted reads. dut_b: DEPTH=12 for out-of-range addresses.
module tb_ram_scan_display;

    logic       clk;
    logic       reset;
    logic [6:0] seg_a;
    logic [3:0] dsel_a;
    logic [6:0] seg_b;
    logic [3:0] dsel_b;

    int n_checks;
    int n_pass;

    ram_scan_display_if #(.DATA_W(4), .ADDR_W(4)) bus_a ();
    ram_scan_display_if #(.DATA_W(4), .ADDR_W(4)) bus_b ();

    ram_scan_display #(
        .DATA_W(4), .ADDR_W(4), .DEPTH(16), .SCAN_DIV(4), .INVERT_OUT(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .seg(seg_a), .digit_sel(dsel_a)
    );

    ram_scan_display #(
        .DATA_W(4), .ADDR_W(4), .DEPTH(12), .SCAN_DIV(4), .INVERT_OUT(1)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .seg(seg_b), .digit_sel(dsel_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [3:0] a, input logic [3:0] d);
        bus_a.cs_n = 1'b0; bus_a.we_n = 1'b0; bus_a.addr = a; bus_a.data_in = d;
        tick();
        bus_a.cs_n = 1'b1; bus_a.we_n = 1'b1;
    endtask

    task automatic read_a(input logic [3:0] a);
        bus_a.cs_n = 1'b0; bus_a.we_n = 1'b1; bus_a.addr = a;
        tick();
        bus_a.cs_n = 1'b1;
    endtask

    task automatic write_b(input logic [3:0] a, input logic [3:0] d);
        bus_b.cs_n = 1'b0; bus_b.we_n = 1'b0; bus_b.addr = a; bus_b.data_in = d;
        tick();
        bus_b.cs_n = 1'b1; bus_b.we_n = 1'b1;
    endtask

    task automatic read_b(input logic [3:0] a);
        bus_b.cs_n = 1'b0; bus_b.we_n = 1'b1; bus_b.addr = a;
        tick();
        bus_b.cs_n = 1'b1;
    endtask

    // Counts busy cycles of dut_a from the current sample until it drops (bounded).
    task automatic count_busy(output int cycles);
        cycles = 0;
        while (bus_a.busy === 1'b1 && cycles < 64) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        int cycles;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.data_out !== 4'h0 || bus_a.data_oe !== 1'b0 || bus_a.busy !== 1'b0) begin
            $display("FAIL reset_port: out=%h oe=%b busy=%b, want 0 0 0",
                     bus_a.data_out, bus_a.data_oe, bus_a.busy);
        end else n_pass++;
        n_checks++;
        if (seg_a !== 7'b1111111 || dsel_a !== 4'h0) begin
            $display("FAIL reset_scan: seg=%b dsel=%h, want 1111111 0", seg_a, dsel_a);
        end else n_pass++;
        n_checks++;
        if (bus_b.data_oe !== 1'b0 || bus_b.busy !== 1'b0) begin
            $display("FAIL reset_b: oe=%b busy=%b, want 0 0", bus_b.data_oe, bus_b.busy);
        end else n_pass++;
        reset = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        tick();
        count_busy(cycles);
        n_checks++;
        if (cycles != 16) begin
            $display("FAIL auto_clear_len: busy cycles=%0d, want 16", cycles);
        end else n_pass++;
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i));
            n_checks++;
            if (bus_a.data_out !== 4'hF) begin
                $display("FAIL auto_clear_data[%0d]: out=%h, want f", i, bus_a.data_out);
            end else n_pass++;
        end
`else
        cycles = 0;
        tick();
        n_checks++;
        if (bus_a.busy !== 1'b0) begin
            $display("FAIL idle_after_reset: busy=%b, want 0", bus_a.busy);
        end else n_pass++;
`endif
    endtask

    task automatic test_write_read_invert();
        write_a(4'd3, 4'hA);
        read_a(4'd3);
        n_checks++;
        if (bus_a.data_out !== 4'h5 || bus_a.data_oe !== 1'b1) begin
            $display("FAIL inv_read: out=%h oe=%b, want 5 1", bus_a.data_out, bus_a.data_oe);
        end else n_pass++;
        tick();
        n_checks++;
        if (bus_a.data_out !== 4'h0 || bus_a.data_oe !== 1'b0) begin
            $display("FAIL cs_high: out=%h oe=%b, want 0 0", bus_a.data_out, bus_a.data_oe);
        end else n_pass++;
        write_a(4'd0, 4'hF);
        read_a(4'd0);
        n_checks++;
        if (bus_a.data_out !== 4'h0 || bus_a.data_oe !== 1'b1) begin
            $display("FAIL addr0_read: out=%h oe=%b, want 0 1", bus_a.data_out, bus_a.data_oe);
        end else n_pass++;
        write_a(4'd15, 4'h2);
        read_a(4'd15);
        n_checks++;
        if (bus_a.data_out !== 4'hD) begin
            $display("FAIL addr15_read: out=%h, want d", bus_a.data_out);
        end else n_pass++;
    endtask

    task automatic test_out_of_range();
        write_b(4'd1, 4'h3);
        write_b(4'd11, 4'h6);
        write_b(4'd13, 4'h7);
        write_b(4'd12, 4'h4);
        read_b(4'd13);
        n_checks++;
        if (bus_b.data_out !== 4'hF || bus_b.data_oe !== 1'b1) begin
            $display("FAIL oor_read13: out=%h oe=%b, want f 1", bus_b.data_out, bus_b.data_oe);
        end else n_pass++;
        read_b(4'd12);
        n_checks++;
        if (bus_b.data_out !== 4'hF) begin
            $display("FAIL oor_read12: out=%h, want f", bus_b.data_out);
        end else n_pass++;
        read_b(4'd1);
        n_checks++;
        if (bus_b.data_out !== 4'hC) begin
            $display("FAIL oor_alias1: out=%h, want c", bus_b.data_out);
        end else n_pass++;
        read_b(4'd11);
        n_checks++;
        if (bus_b.data_out !== 4'h9) begin
            $display("FAIL last_word: out=%h, want 9", bus_b.data_out);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        write_a(4'd4, 4'h5);
        write_a(4'd5, 4'h6);
        bus_a.cs_n = 1'b0; bus_a.we_n = 1'b1; bus_a.addr = 4'd4;
        tick();
        n_checks++;
        if (bus_a.data_out !== 4'hA || bus_a.data_oe !== 1'b1) begin
            $display("FAIL b2b_read4: out=%h oe=%b, want a 1", bus_a.data_out, bus_a.data_oe);
        end else n_pass++;
        bus_a.addr = 4'd5;
        tick();
        n_checks++;
        if (bus_a.data_out !== 4'h9 || bus_a.data_oe !== 1'b1) begin
            $display("FAIL b2b_read5: out=%h oe=%b, want 9 1", bus_a.data_out, bus_a.data_oe);
        end else n_pass++;
        bus_a.we_n = 1'b0; bus_a.addr = 4'd4; bus_a.data_in = 4'hC;
        tick();
        bus_a.we_n = 1'b1;
        tick();
        bus_a.cs_n = 1'b1;
        n_checks++;
        if (bus_a.data_out !== 4'h3) begin
            $display("FAIL write_then_read: out=%h, want 3", bus_a.data_out);
        end else n_pass++;
    endtask

    task automatic test_clear_collision();
        int cycles;
        int bad;
        for (int i = 0; i < 16; i++) write_a(4'(i), 4'h9);
        bus_a.clear_req = 1'b1;
        bus_a.cs_n = 1'b0; bus_a.we_n = 1'b0; bus_a.addr = 4'd2; bus_a.data_in = 4'h5;
        tick();
        bus_a.clear_req = 1'b0;
        bus_a.we_n = 1'b1;
        cycles = 0;
        bad = 0;
        while (bus_a.busy === 1'b1 && cycles < 64) begin
            if (seg_a !== 7'b1111111 || bus_a.data_oe !== 1'b0) bad++;
            if (cycles == 3) bus_a.clear_req = 1'b1;
            else bus_a.clear_req = 1'b0;
            cycles++;
            tick();
        end
        bus_a.clear_req = 1'b0;
        bus_a.cs_n = 1'b1;
        n_checks++;
        if (cycles != 16) begin
            $display("FAIL clear_len: busy cycles=%0d, want 16", cycles);
        end else n_pass++;
        n_checks++;
        if (bad != 0) begin
            $display("FAIL clear_blank_noread: bad cycles=%0d, want 0", bad);
        end else n_pass++;
        tick();
        n_checks++;
        if (bus_a.busy !== 1'b0) begin
            $display("FAIL clear_reentry: busy=%b, want 0", bus_a.busy);
        end else n_pass++;
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i));
            n_checks++;
            if (bus_a.data_out !== 4'hF) begin
                $display("FAIL clear_data[%0d]: out=%h, want f", i, bus_a.data_out);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        logic [3:0] exp;
        for (int i = 0; i < 16; i++) write_a(4'(i), 4'h9);
        bus_a.clear_req = 1'b1;
        tick();
        bus_a.clear_req = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (bus_a.busy !== 1'b1) begin
            $display("FAIL midclear_busy: busy=%b, want 1", bus_a.busy);
        end else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus_a.busy !== 1'b0) begin
            $display("FAIL abort_busy: busy=%b, want 0", bus_a.busy);
        end else n_pass++;
`ifdef RAM_CLEAR_ON_RESET_EN
        tick();
        count_busy(cycles);
`else
        cycles = 0;
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef RAM_CLEAR_ON_RESET_EN
            exp = 4'hF;
`else
            exp = (i < 5) ? 4'hF : 4'h6;
`endif
            read_a(4'(i));
            n_checks++;
            if (bus_a.data_out !== exp) begin
                $display("FAIL abort_data[%0d]: out=%h, want %h", i, bus_a.data_out, exp);
            end else n_pass++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        int found;
        int bad;
        write_a(4'd0, 4'hA);
        write_a(4'd1, 4'h1);
        found = 0;
        prev = dsel_a;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (prev == 4'd15 && dsel_a == 4'd0) found = 1;
            prev = dsel_a;
        end
        n_checks++;
        if (found != 1) begin
            $display("FAIL scan_wrap: digit_sel never went 15->0, found=%0d want 1", found);
        end else n_pass++;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (dsel_a !== 4'd0 || seg_a !== 7'b0001000) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL scan_digit0: bad samples=%0d, want 0 (dsel=%h seg=%b)",
                     bad, dsel_a, seg_a);
        end else n_pass++;
        n_checks++;
        if (dsel_a !== 4'd1 || seg_a !== 7'b1111001) begin
            $display("FAIL scan_digit1: dsel=%h seg=%b, want 1 1111001", dsel_a, seg_a);
        end else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus_a.cs_n = 1'b1; bus_a.we_n = 1'b1; bus_a.addr = '0; bus_a.data_in = '0;
        bus_a.clear_req = 1'b0;
        bus_b.cs_n = 1'b1; bus_b.we_n = 1'b1; bus_b.addr = '0; bus_b.data_in = '0;
        bus_b.clear_req = 1'b0;
        test_reset();
        test_write_read_invert();
        test_out_of_range();
        test_back_to_back();
        test_clear_collision();
        test_reset_mid_clear();
        test_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
